// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state encodings for the sequential ALU.
package seq_alu_pkg;

   // Opcode encodings. Any value not listed here is an unknown opcode.
   localparam logic [4:0] OP_ADD     = 5'd0;
   localparam logic [4:0] OP_SUB     = 5'd1;
   localparam logic [4:0] OP_SUBU    = 5'd2;
   localparam logic [4:0] OP_AND     = 5'd3;
   localparam logic [4:0] OP_OR      = 5'd4;
   localparam logic [4:0] OP_XOR     = 5'd5;
   localparam logic [4:0] OP_XNOR    = 5'd6;
   localparam logic [4:0] OP_LSHIFT  = 5'd7;
   localparam logic [4:0] OP_LRSHIFT = 5'd8;
   localparam logic [4:0] OP_ARSHIFT = 5'd9;
   localparam logic [4:0] OP_MUL     = 5'd10;
   localparam logic [4:0] OP_DIV     = 5'd11;
   localparam logic [4:0] OP_DIVU    = 5'd12;
   localparam logic [4:0] OP_REM     = 5'd13;
   localparam logic [4:0] OP_REMU    = 5'd14;

   // Control FSM states.
   typedef enum logic [1:0] {
      ALU_ST_IDLE    = 2'd0,
      ALU_ST_MUL_RUN = 2'd1,
      ALU_ST_DIV_RUN = 2'd2
   } alu_state_t;

endpackage

// File: rtl/seq_alu_divider.sv
// Restoring divider, one quotient bit per cycle, XLEN cycles per divide.
// Signed division works on magnitudes; the sign fix-up is applied to the
// outputs so quotient/remainder are final in the cycle done is high.
module seq_divider
   import seq_alu_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            abort,
   input  logic            start,
   input  logic            sign_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   logic            run;
   logic [SHW-1:0]  cnt;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvs;
   logic            neg_q;
   logic            neg_r;

   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] diff;
   logic            ge;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic            unused_bits;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted = {rem, quo[XLEN-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs};
      ge      = ~diff[XLEN+1];
      rem_nx  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_nx  = {quo[XLEN-2:0], ge};
   end

   // Both of these bits are provably zero whenever they would be kept.
   assign unused_bits = diff[XLEN] ^ shifted[XLEN];

   assign done      = run && (cnt == SHW'(XLEN - 1));
   assign quotient  = neg_q ? ('0 - quo_nx) : quo_nx;
   assign remainder = neg_r ? ('0 - rem_nx) : rem_nx;

   // Operand capture at start, then one step per cycle until the last bit.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         run   <= 1'b0;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (start) begin
         run   <= 1'b1;
         cnt   <= '0;
         rem   <= '0;
         quo   <= (sign_op && a[XLEN-1]) ? ('0 - a) : a;
         dvs   <= (sign_op && b[XLEN-1]) ? ('0 - b) : b;
         neg_q <= sign_op && (a[XLEN-1] ^ b[XLEN-1]);
         neg_r <= sign_op && a[XLEN-1];
      end else if (run) begin
         rem <= rem_nx;
         quo <= quo_nx;
         if (done) begin
            run <= 1'b0;
            cnt <= '0;
         end else begin
            cnt <= cnt + SHW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready on input and output.
// Handshake: a beat moves on either side only when valid && ready are both
// high at a rising clk edge; valid never waits on ready, and in_ready is
// dropped while an engine runs, while the result register is stalled, and
// during a kill cycle.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_ITER = 1,
   localparam int SHW     = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res,
   output logic            zero,
   output logic            illegal_op,
   output logic            busy,
   output logic [1:0]      state_dbg
);

   alu_state_t      state;
   alu_state_t      state_nx;
   logic [SHW-1:0]  cnt;
   logic            last_iter;
   logic            accept;
   logic            is_div_op;
   logic            start_mul;
   logic            start_div;
   logic            single_wr;
   logic            run_done;
   logic            wr_en;
   logic [XLEN-1:0] wr_res;
   logic [XLEN-1:0] comb_res;
   logic            comb_ill;
   logic            op_rem;

   logic [XLEN-1:0] mul_acc;
   logic [XLEN-1:0] mul_mcand;
   logic [XLEN-1:0] mul_mplier;
   logic [XLEN-1:0] mul_acc_nx;

   logic [XLEN-1:0] div_quo;
   logic [XLEN-1:0] div_rem;
   logic            div_done;

   assign in_ready  = (state == ALU_ST_IDLE) && (!out_valid || out_ready) && !kill;
   assign accept    = in_valid && in_ready;
   assign busy      = (state != ALU_ST_IDLE);
   assign state_dbg = state;
   assign zero      = (res == '0);
   assign last_iter = (cnt == SHW'(XLEN - 1));

   // Single-cycle datapath; also supplies the divide-by-zero results.
   always_comb begin
      comb_res  = '0;
      comb_ill  = 1'b0;
      is_div_op = 1'b0;
      case (alu_op)
         OP_ADD:     comb_res = r1 + r2;
         OP_SUB:     comb_res = r1 - r2;
         OP_SUBU:    comb_res = r1 - r2;
         OP_AND:     comb_res = r1 & r2;
         OP_OR:      comb_res = r1 | r2;
         OP_XOR:     comb_res = r1 ^ r2;
         OP_XNOR:    comb_res = ~(r1 ^ r2);
         OP_LSHIFT:  comb_res = r1 << r2[SHW-1:0];
         OP_LRSHIFT: comb_res = r1 >> r2[SHW-1:0];
         OP_ARSHIFT: comb_res = $signed(r1) >>> r2[SHW-1:0];
         OP_MUL: begin
            if (MUL_ITER == 0) comb_res = r1 * r2;
         end
         OP_DIV, OP_DIVU: begin
            is_div_op = 1'b1;
            comb_res  = '1;
            comb_ill  = 1'b1;
         end
         OP_REM, OP_REMU: begin
            is_div_op = 1'b1;
            comb_res  = r1;
            comb_ill  = 1'b1;
         end
         default: comb_ill = 1'b1;
      endcase
   end

   assign start_mul = accept && (alu_op == OP_MUL) && (MUL_ITER != 0);
   assign start_div = accept && is_div_op && (r2 != '0);
   assign single_wr = accept && !start_mul && !start_div;
   assign run_done  = ((state == ALU_ST_MUL_RUN) && last_iter) ||
                      ((state == ALU_ST_DIV_RUN) && div_done);
   assign wr_en     = single_wr || run_done;

   // Result selection for the output register write.
   always_comb begin
      wr_res = comb_res;
      if (!single_wr) begin
         if (state == ALU_ST_MUL_RUN) wr_res = mul_acc_nx;
         else                         wr_res = op_rem ? div_rem : div_quo;
      end
   end

   // Control FSM next state; kill forces IDLE.
   always_comb begin
      state_nx = state;
      if (kill) begin
         state_nx = ALU_ST_IDLE;
      end else begin
         case (state)
            ALU_ST_IDLE: begin
               if (start_mul)      state_nx = ALU_ST_MUL_RUN;
               else if (start_div) state_nx = ALU_ST_DIV_RUN;
            end
            ALU_ST_MUL_RUN: if (last_iter) state_nx = ALU_ST_IDLE;
            ALU_ST_DIV_RUN: if (div_done)  state_nx = ALU_ST_IDLE;
            default:        state_nx = ALU_ST_IDLE;
         endcase
      end
   end

   // Control FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ALU_ST_IDLE;
      else     state <= state_nx;
   end

   // Iteration counter, shared by both engines.
   always_ff @(posedge clk) begin
      if (rst || kill)                  cnt <= '0;
      else if (state == ALU_ST_IDLE)    cnt <= '0;
      else if (last_iter)               cnt <= '0;
      else                              cnt <= cnt + SHW'(1);
   end

   assign mul_acc_nx = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

   // Shift-add multiplier: one multiplier bit per cycle, low XLEN bits kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else if (start_mul) begin
         mul_acc    <= '0;
         mul_mcand  <= r1;
         mul_mplier <= r2;
      end else if (state == ALU_ST_MUL_RUN) begin
         mul_acc    <= mul_acc_nx;
         mul_mcand  <= mul_mcand << 1;
         mul_mplier <= mul_mplier >> 1;
      end
   end

   // Remembers whether the running divide should return the remainder.
   always_ff @(posedge clk) begin
      if (rst)            op_rem <= 1'b0;
      else if (start_div) op_rem <= (alu_op == OP_REM) || (alu_op == OP_REMU);
   end

   seq_divider #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .abort     (kill),
      .start     (start_div),
      .sign_op   ((alu_op == OP_DIV) || (alu_op == OP_REM)),
      .a         (r1),
      .b         (r2),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Output register: written on completion, cleared on transfer or kill.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         out_valid  <= 1'b0;
         res        <= '0;
         illegal_op <= 1'b0;
      end else if (wr_en) begin
         out_valid  <= 1'b1;
         res        <= wr_res;
         illegal_op <= single_wr ? comb_ill : 1'b0;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32, iterative MUL).
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            kill;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_op;
   logic [XLEN-1:0] r1;
   logic [XLEN-1:0] r2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;
   logic            zero;
   logic            illegal_op;
   logic            busy;
   logic [1:0]      state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [XLEN-1:0] exp_q[$];

   typedef struct {
      logic [4:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
      logic            ill;
      int              lat;
   } vec_t;

   vec_t vecs[20];

   seq_alu #(.XLEN(XLEN), .MUL_ITER(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .kill       (kill),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .r1         (r1),
      .r2         (r2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .res        (res),
      .zero       (zero),
      .illegal_op (illegal_op),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model straight from the arithmetic rules.
   function automatic void model(input logic [4:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, output logic [XLEN-1:0] r,
                                 output logic ill, output int lat);
      longint          sa = $signed(a);
      longint          sb = $signed(b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      int              sh = int'(b % XLEN);
      r = '0; ill = 1'b0; lat = 1;
      case (op)
         OP_ADD:     r = XLEN'(ua + ub);
         OP_SUB:     r = XLEN'(sa - sb);
         OP_SUBU:    r = XLEN'(ua - ub);
         OP_AND:     r = a & b;
         OP_OR:      r = a | b;
         OP_XOR:     r = a ^ b;
         OP_XNOR:    r = ~(a ^ b);
         OP_LSHIFT:  r = XLEN'(ua << sh);
         OP_LRSHIFT: r = XLEN'(ua >> sh);
         OP_ARSHIFT: r = XLEN'(sa >>> sh);
         OP_MUL: begin r = XLEN'(ua * ub); lat = XLEN + 1; end
         OP_DIV: begin
            if (b == 0) begin r = '1; ill = 1'b1; end
            else begin r = XLEN'(sa / sb); lat = XLEN + 1; end
         end
         OP_DIVU: begin
            if (b == 0) begin r = '1; ill = 1'b1; end
            else begin r = XLEN'(ua / ub); lat = XLEN + 1; end
         end
         OP_REM: begin
            if (b == 0) begin r = a; ill = 1'b1; end
            else begin r = XLEN'(sa % sb); lat = XLEN + 1; end
         end
         OP_REMU: begin
            if (b == 0) begin r = a; ill = 1'b1; end
            else begin r = XLEN'(ua % ub); lat = XLEN + 1; end
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Driver: issue one op at a negedge, wait for its result, check it.
   // Expected result is taken from the front of exp_q.
   task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic e_ill, input int e_lat, input string tag);
      int w;
      int lat;
      int busy_cnt;
      logic [XLEN-1:0] e_res;
      e_res     = exp_q.pop_front();
      alu_op    = op;
      r1        = a;
      r2        = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check({tag, " in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      r1 = $urandom;
      r2 = $urandom;
      alu_op = 5'($urandom);
      lat = 1;
      busy_cnt = 0;
      while (!out_valid && lat < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(e_lat));
      check({tag, " res"}, 64'(res), 64'(e_res));
      check({tag, " illegal_op"}, 64'(illegal_op), 64'(e_ill));
      check({tag, " zero"}, 64'(zero), 64'(e_res == '0));
      check({tag, " busy cycles"}, 64'(busy_cnt), (e_lat > 1) ? 64'(XLEN) : 64'd0);
   endtask

   // Abort an in-flight DIVU on iteration 10 via kill (use_rst=0) or rst.
   task automatic abort_seq(input logic use_rst, input string tag);
      int seen;
      alu_op    = OP_DIVU;
      r1        = 32'd1000;
      r2        = 32'd3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check({tag, " busy before abort"}, 64'(busy), 64'd1);
      if (use_rst) rst = 1'b1;
      else begin
         kill = 1'b1;
         check({tag, " in_ready during kill"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      kill = 1'b0;
      check({tag, " busy after"}, 64'(busy), 64'd0);
      check({tag, " out_valid after"}, 64'(out_valid), 64'd0);
      check({tag, " res after"}, 64'(res), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      check({tag, " no late result"}, 64'(seen), 64'd0);
      exp_q.push_back(32'd2);
      run_op(OP_ADD, 32'd1, 32'd1, 1'b0, 1, {tag, " add after"});
   endtask

   initial begin
      logic [XLEN-1:0] e_res;
      logic            e_ill;
      int              e_lat;
      int              lat;
      int              rdy_seen;
      logic [4:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;

      vecs[0]  = '{OP_ADD,     32'd5,          32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1};
      vecs[1]  = '{OP_XOR,     32'hFFFF_0000,  32'h00FF_FF00, 32'hFF00_FF00, 1'b0, 1};
      vecs[2]  = '{OP_ARSHIFT, 32'h8000_0000,  32'h0000_0024, 32'hF800_0000, 1'b0, 1};
      vecs[3]  = '{OP_DIV,     32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
      vecs[4]  = '{OP_REM,     32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 33};
      vecs[5]  = '{OP_DIV,     32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33};
      vecs[6]  = '{OP_REM,     32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
      vecs[7]  = '{OP_DIVU,    32'd10,         32'd0,         32'hFFFF_FFFF, 1'b1, 1};
      vecs[8]  = '{OP_REMU,    32'd10,         32'd0,         32'd10,        1'b1, 1};
      vecs[9]  = '{OP_MUL,     32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b0, 33};
      vecs[10] = '{OP_DIVU,    32'd100,        32'd7,         32'd14,        1'b0, 33};
      vecs[11] = '{OP_REMU,    32'd100,        32'd7,         32'd2,         1'b0, 33};
      vecs[12] = '{OP_SUB,     32'd3,          32'd5,         32'hFFFF_FFFE, 1'b0, 1};
      vecs[13] = '{OP_LSHIFT,  32'd1,          32'h0000_0021, 32'd2,         1'b0, 1};
      vecs[14] = '{OP_LRSHIFT, 32'h8000_0000,  32'd31,        32'd1,         1'b0, 1};
      vecs[15] = '{OP_XNOR,    32'd0,          32'd0,         32'hFFFF_FFFF, 1'b0, 1};
      vecs[16] = '{5'd31,      32'd3,          32'd4,         32'd0,         1'b1, 1};
      vecs[17] = '{OP_DIV,     32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
      vecs[18] = '{OP_REM,     32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 33};
      vecs[19] = '{OP_MUL,     32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFD, 1'b0, 33};

      // Reset.
      rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = OP_ADD; r1 = '0; r2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset res", 64'(res), 64'd0);
      check("reset zero", 64'(zero), 64'd1);
      check("reset illegal_op", 64'(illegal_op), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);

      // Directed vector table.
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(vecs[i].res);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ill, vecs[i].lat, $sformatf("vec%0d", i));
      end

      // Back-to-back single-cycle ops at full throughput.
      alu_op = OP_XOR; r1 = 32'hFFFF_0000; r2 = 32'h00FF_FF00;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("b2b first valid", 64'(out_valid), 64'd1);
      check("b2b first res", 64'(res), 64'hFF00_FF00);
      check("b2b second in_ready", 64'(in_ready), 64'd1);
      alu_op = OP_ARSHIFT; r1 = 32'h8000_0000; r2 = 32'h24;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b second valid", 64'(out_valid), 64'd1);
      check("b2b second res", 64'(res), 64'hF800_0000);
      @(negedge clk);
      check("b2b drained", 64'(out_valid), 64'd0);

      // Stalled MUL result held stable.
      alu_op = OP_MUL; r1 = 32'h0001_0000; r2 = 32'h0001_0000;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      alu_op = OP_ADD; r1 = 32'd1; r2 = 32'd2;
      lat = 1; rdy_seen = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen++;
         @(negedge clk);
         lat++;
      end
      check("stall latency", 64'(lat), 64'd33);
      for (int k = 0; k < 5; k++) begin
         if (in_ready) rdy_seen++;
         check($sformatf("stall hold%0d res", k), 64'(res), 64'd0);
         check($sformatf("stall hold%0d zero", k), 64'(zero), 64'd1);
         check($sformatf("stall hold%0d valid", k), 64'(out_valid), 64'd1);
         @(negedge clk);
      end
      check("stall in_ready never high", 64'(rdy_seen), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("stall transfer clears", 64'(out_valid), 64'd0);

      // Abort sequences.
      abort_seq(1'b0, "kill");
      abort_seq(1'b1, "rst");

      // Randomized ops against the reference model.
      for (int i = 0; i < 150; i++) begin
         int sel = int'($urandom_range(0, 15));
         op = (sel == 15) ? 5'($urandom_range(15, 31)) : 5'(sel);
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'($urandom_range(0, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 9));
            3: b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         model(op, a, b, e_res, e_ill, e_lat);
         exp_q.push_back(e_res);
         run_op(op, a, b, e_ill, e_lat, $sformatf("rnd%0d op%0d", i, op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
